pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Program-counter sequencer for the RV32I pipeline: owns the PC register, holds a boot FSM,
//  and resolves control flow in EX using branch/jump immediates from the immediate generator.
//  Drives the fetch address and issues flush/redirect to the IF/ID and ID/EX registers.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset; first fetch address
//  BOOT_CYCLES 2              cycles in BOOT before o_pc_valid rises (range 1..15)
// PORTS
//  i_clk          in   1   clock, rising edge
//  i_reset        in   1   synchronous, active-high reset
//  i_stall        in   1   hazard-unit stall: hold PC
//  i_ex_valid     in   1   EX stage holds a valid instruction
//  i_ex_is_br     in   1   EX instr is BEQ/BNE/BLT/BGE/BLTU/BGEU
//  i_ex_br_taken  in   1   branch comparator result (used only with i_ex_is_br)
//  i_ex_is_jal    in   1   EX instr is JAL
//  i_ex_is_jalr   in   1   EX instr is JALR
//  i_ex_pc        in   32  PC of EX instruction
//  i_ex_rs1       in   32  forwarded rs1 value
//  i_imm_I        in   32  sign-extended I immediate of EX instr
//  i_imm_B        in   32  sign-extended B immediate (bit0=0)
//  i_imm_J        in   32  sign-extended J immediate (bit0=0)
//  o_pc           out  32  fetch address (registered)
//  o_pc_valid     out  1   o_pc is a real fetch (registered)
//  o_flush        out  1   kill IF/ID and ID/EX contents at this edge (combinational)
//  o_link         out  32  i_ex_pc + 4, rd value for JAL/JALR (combinational)
//  o_halted       out  1   sequencer in HALT (registered)
//  o_trap_pc      out  32  PC of instruction that caused HALT (registered)
// BEHAVIOUR
//  Reset (any state, any cycle): state<=BOOT, o_pc<=RESET_PC, o_pc_valid<=0, o_halted<=0,
//   o_trap_pc<=0, boot counter<=0. Reset dominates all other inputs.
//  FSM: BOOT -> RUN when counter reaches BOOT_CYCLES-1; RUN -> HALT on misaligned target
//   (macro only); HALT -> BOOT only via reset. BOOT/HALT ignore i_stall and EX inputs;
//   o_flush=0 and o_pc_valid=0 in both.
//  take = RUN & i_ex_valid & (i_ex_is_jalr | i_ex_is_jal | (i_ex_is_br & i_ex_br_taken)).
//  Target priority if flags overlap: JALR > JAL > BR.
//   JALR: (i_ex_rs1 + i_imm_I) & ~32'h1;  JAL: i_ex_pc + i_imm_J;  BR: i_ex_pc + i_imm_B.
//  All adds modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal, no flag.
//  RUN next-PC at edge: take -> target; else i_stall -> hold; else o_pc + 4.
//  Redirect beats stall: take with i_stall=1 still loads target and asserts o_flush.
//  o_flush = take; one cycle per redirect; target appears on o_pc the next cycle (1-cycle latency).
//  Back-to-back takes: each is honoured; the second comes from the EX instr after the flush.
//  Not-taken branch: no flush, PC flow unchanged.
//  o_pc_valid = 1 in every RUN cycle, including stalled ones (fetch repeats the held address).
// CONFIGURATION
//  PC_SEQ_MISALIGN_TRAP_EN defined: when take and target[1:0]!=2'b00, the edge loads
//   state<=HALT, o_trap_pc<=i_ex_pc, o_halted<=1, o_pc unchanged; o_flush=1 in that cycle.
//  Not defined: target[1:0] forced to 2'b00 before loading o_pc; HALT unreachable;
//   o_halted and o_trap_pc tied 0.
// TESTING
//  Reset, BOOT_CYCLES=2, no stall -> o_pc_valid=0 for 2 cycles, then o_pc 0x0,0x4,0x8 with valid=1.
//  RUN at PC 0x10, i_stall=1 for 3 cycles -> o_pc held at 0x10, o_flush=0, then resumes at 0x14.
//  BEQ taken, i_ex_pc=0x20, i_imm_B=-8 -> o_flush=1 that cycle, next o_pc=0x18; not-taken -> no flush.
//  JALR, rs1=0x101, imm_I=0x4, with i_stall=1 -> o_flush=1, next o_pc=0x104, o_link=i_ex_pc+4.
//  JAL, i_ex_pc=0xFFFF_FFF0, imm_J=0x20 -> next o_pc=0x10 (wrap); i_reset pulsed mid-stream -> BOOT, o_pc=RESET_PC.
//  JAL imm_J=0x6 from 0x40: with macro -> HALT, o_trap_pc=0x40, o_pc_valid=0; without -> o_pc=0x44.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot FSM, PC register and EX-stage redirect resolution.
// Optional PC_SEQ_MISALIGN_TRAP_EN halts on a misaligned taken target instead of forcing alignment.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BOOT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_br,
    input  logic        i_ex_br_taken,
    input  logic        i_ex_is_jal,
    input  logic        i_ex_is_jalr,
    input  logic [31:0] i_ex_pc,
    input  logic [31:0] i_ex_rs1,
    input  logic [31:0] i_imm_I,
    input  logic [31:0] i_imm_B,
    input  logic [31:0] i_imm_J,
    output logic [31:0] o_pc,
    output logic        o_pc_valid,
    output logic        o_flush,
    output logic [31:0] o_link,
    output logic        o_halted,
    output logic [31:0] o_trap_pc
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t      state;
    logic [3:0]  boot_cnt;
    logic        take;
    logic [31:0] target;

    // Overlapping control-flow flags resolve as JALR over JAL over branch.
    always_comb begin
        target = i_ex_pc + i_imm_B;
        if (i_ex_is_jalr)
            target = (i_ex_rs1 + i_imm_I) & ~32'h1;
        else if (i_ex_is_jal)
            target = i_ex_pc + i_imm_J;
    end

    assign take    = (state == RUN) & i_ex_valid &
                     (i_ex_is_jalr | i_ex_is_jal | (i_ex_is_br & i_ex_br_taken));
    assign o_flush = take;
    assign o_link  = i_ex_pc + 32'd4;

`ifndef PC_SEQ_MISALIGN_TRAP_EN
    assign o_halted  = 1'b0;
    assign o_trap_pc = 32'h0;
`endif

    // A redirect wins over stall; otherwise a stall holds the fetch address.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= BOOT;
            o_pc       <= RESET_PC;
            o_pc_valid <= 1'b0;
            boot_cnt   <= 4'd0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
            o_halted   <= 1'b0;
            o_trap_pc  <= 32'h0;
`endif
        end else begin
            case (state)
                BOOT: begin
                    if (boot_cnt == BOOT_LAST) begin
                        state      <= RUN;
                        o_pc_valid <= 1'b1;
                    end else begin
                        boot_cnt <= boot_cnt + 4'd1;
                    end
                end
                RUN: begin
                    if (take) begin
`ifdef PC_SEQ_MISALIGN_TRAP_EN
                        if (target[1:0] != 2'b00) begin
                            state      <= HALT;
                            o_pc_valid <= 1'b0;
                            o_halted   <= 1'b1;
                            o_trap_pc  <= i_ex_pc;
                        end else begin
                            o_pc <= target;
                        end
`else
                        o_pc <= target & ~32'h3;
`endif
                    end else if (!i_stall) begin
                        o_pc <= o_pc + 32'd4;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (BOOT_CYCLES=2, RESET_PC=0).
module tb_pc_sequencer;

    logic        i_clk;
    logic        i_reset;
    logic        i_stall;
    logic        i_ex_valid;
    logic        i_ex_is_br;
    logic        i_ex_br_taken;
    logic        i_ex_is_jal;
    logic        i_ex_is_jalr;
    logic [31:0] i_ex_pc;
    logic [31:0] i_ex_rs1;
    logic [31:0] i_imm_I;
    logic [31:0] i_imm_B;
    logic [31:0] i_imm_J;
    logic [31:0] o_pc;
    logic        o_pc_valid;
    logic        o_flush;
    logic [31:0] o_link;
    logic        o_halted;
    logic [31:0] o_trap_pc;

    int checks;
    int failures;

    pc_sequencer #(
        .RESET_PC   (32'h0000_0000),
        .BOOT_CYCLES(2)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_stall      (i_stall),
        .i_ex_valid   (i_ex_valid),
        .i_ex_is_br   (i_ex_is_br),
        .i_ex_br_taken(i_ex_br_taken),
        .i_ex_is_jal  (i_ex_is_jal),
        .i_ex_is_jalr (i_ex_is_jalr),
        .i_ex_pc      (i_ex_pc),
        .i_ex_rs1     (i_ex_rs1),
        .i_imm_I      (i_imm_I),
        .i_imm_B      (i_imm_B),
        .i_imm_J      (i_imm_J),
        .o_pc         (o_pc),
        .o_pc_valid   (o_pc_valid),
        .o_flush      (o_flush),
        .o_link       (o_link),
        .o_halted     (o_halted),
        .o_trap_pc    (o_trap_pc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic br, input logic taken,
                                 input logic jal, input logic jalr, input logic [31:0] pc);
        i_ex_valid    = valid;
        i_ex_is_br    = br;
        i_ex_br_taken = taken;
        i_ex_is_jal   = jal;
        i_ex_is_jalr  = jalr;
        i_ex_pc       = pc;
        #1;
    endtask

    initial begin
        logic [31:0] pc_before;
        checks   = 0;
        failures = 0;
        i_reset  = 1'b1;
        i_stall  = 1'b0;
        i_ex_rs1 = 32'h0;
        i_imm_I  = 32'h0;
        i_imm_B  = 32'h0;
        i_imm_J  = 32'h0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        tick();
        tick();
        checkOutput("reset_pc", o_pc, 32'h0);
        checkOutput("reset_valid", {31'b0, o_pc_valid}, 32'h0);
        checkOutput("reset_halted", {31'b0, o_halted}, 32'h0);
        checkOutput("reset_trap_pc", o_trap_pc, 32'h0);
        checkOutput("reset_flush", {31'b0, o_flush}, 32'h0);

        // Boot: valid low for two cycles, then sequential fetch
        i_reset = 1'b0;
        tick();
        checkOutput("boot_valid", {31'b0, o_pc_valid}, 32'h0);
        tick();
        checkOutput("run_valid", {31'b0, o_pc_valid}, 32'h1);
        checkOutput("run_pc0", o_pc, 32'h0);
        tick();
        checkOutput("run_pc4", o_pc, 32'h4);
        tick();
        checkOutput("run_pc8", o_pc, 32'h8);
        tick();
        tick();
        checkOutput("run_pc10", o_pc, 32'h10);

        // Stall three cycles at 0x10
        i_stall = 1'b1;
        #1;
        checkOutput("stall_flush", {31'b0, o_flush}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_hold", o_pc, 32'h10);
            checkOutput("stall_valid", {31'b0, o_pc_valid}, 32'h1);
        end
        i_stall = 1'b0;
        tick();
        checkOutput("stall_resume", o_pc, 32'h14);

        // Taken BEQ then not-taken
        i_imm_B = 32'hFFFF_FFF8;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20);
        checkOutput("beq_flush", {31'b0, o_flush}, 32'h1);
        tick();
        checkOutput("beq_target", o_pc, 32'h18);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20);
        checkOutput("bne_noflush", {31'b0, o_flush}, 32'h0);
        tick();
        checkOutput("bnt_seq", o_pc, 32'h1C);

        // JALR under stall
        i_ex_rs1 = 32'h101;
        i_imm_I  = 32'h4;
        i_stall  = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h30);
        checkOutput("jalr_flush", {31'b0, o_flush}, 32'h1);
        checkOutput("jalr_link", o_link, 32'h34);
        tick();
        checkOutput("jalr_target", o_pc, 32'h104);
        i_stall = 1'b0;

        // Priority with overlapping flags, back to back
        i_ex_rs1 = 32'h200;
        i_imm_I  = 32'h0;
        i_imm_J  = 32'h40;
        i_imm_B  = 32'h80;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100);
        tick();
        checkOutput("prio_jalr", o_pc, 32'h200);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100);
        checkOutput("b2b_flush", {31'b0, o_flush}, 32'h1);
        tick();
        checkOutput("prio_jal", o_pc, 32'h140);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100);
        checkOutput("invalid_noflush", {31'b0, o_flush}, 32'h0);
        tick();
        checkOutput("invalid_seq", o_pc, 32'h144);

        // JAL wrap past 2^32
        i_imm_J = 32'h20;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0);
        tick();
        checkOutput("jal_wrap", o_pc, 32'h10);

        // Reset mid-stream with a take pending; BOOT ignores EX inputs
        i_reset = 1'b1;
        tick();
        checkOutput("mid_reset_pc", o_pc, 32'h0);
        checkOutput("mid_reset_valid", {31'b0, o_pc_valid}, 32'h0);
        checkOutput("mid_reset_flush", {31'b0, o_flush}, 32'h0);
        i_reset = 1'b0;
        tick();
        checkOutput("reboot_flush", {31'b0, o_flush}, 32'h0);
        checkOutput("reboot_pc", o_pc, 32'h0);
        tick();
        checkOutput("reboot_valid", {31'b0, o_pc_valid}, 32'h1);
        checkOutput("reboot_pc_run", o_pc, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("reboot_pc4", o_pc, 32'h4);

        // Misaligned JAL target 0x46
        pc_before = o_pc;
        i_imm_J = 32'h6;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40);
        checkOutput("mis_flush", {31'b0, o_flush}, 32'h1);
        tick();
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        checkOutput("mis_halted", {31'b0, o_halted}, 32'h1);
        checkOutput("mis_trap_pc", o_trap_pc, 32'h40);
        checkOutput("mis_valid", {31'b0, o_pc_valid}, 32'h0);
        checkOutput("mis_pc_hold", o_pc, pc_before);
        checkOutput("halt_noflush", {31'b0, o_flush}, 32'h0);
        tick();
        checkOutput("halt_pc_hold", o_pc, pc_before);
        checkOutput("halt_stays", {31'b0, o_halted}, 32'h1);
`else
        checkOutput("mis_aligned_pc", o_pc, 32'h44);
        checkOutput("mis_halted", {31'b0, o_halted}, 32'h0);
        checkOutput("mis_trap_pc", o_trap_pc, 32'h0);
        checkOutput("mis_valid", {31'b0, o_pc_valid}, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("mis_seq", o_pc, 32'h48);
        checkOutput("mis_pc_before_unused", o_pc, pc_before + 32'h44);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
